// File: rtl/alu_design.sv
// Registered integer ALU: arithmetic (MODE=1) and logical (MODE=0) command sets with carry/compare/error flags.
// Define ALU_MULT_EN to add the two-cycle multiply commands (arithmetic CMD 9/10); otherwise they are illegal.
module alu_design #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic [1:0]             INP_VALID,
  input  logic                   MODE,
  input  logic [CMD_WIDTH-1:0]   CMD,
  input  logic [WIDTH-1:0]       OPA,
  input  logic [WIDTH-1:0]       OPB,
  input  logic                   CIN,
  output logic [2*WIDTH-1:0]     RES,
  output logic                   OFLOW,
  output logic                   COUT,
  output logic                   G,
  output logic                   E,
  output logic                   L,
  output logic                   ERR
);

  localparam int SHW = $clog2(WIDTH);

  // Arithmetic command codes
  localparam logic [CMD_WIDTH-1:0] A_ADD   = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] A_SUB   = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] A_ADDC  = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] A_SUBC  = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] A_INCA  = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] A_DECA  = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] A_INCB  = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] A_DECB  = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] A_CMP   = CMD_WIDTH'(8);
`ifdef ALU_MULT_EN
  localparam logic [CMD_WIDTH-1:0] A_MULI  = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] A_MULS  = CMD_WIDTH'(10);
`endif

  // Logical command codes
  localparam logic [CMD_WIDTH-1:0] L_AND   = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] L_NAND  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] L_OR    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] L_NOR   = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] L_XOR   = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] L_XNOR  = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] L_NOTA  = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] L_NOTB  = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] L_SHR1A = CMD_WIDTH'(8);
  localparam logic [CMD_WIDTH-1:0] L_SHL1A = CMD_WIDTH'(9);
  localparam logic [CMD_WIDTH-1:0] L_SHR1B = CMD_WIDTH'(10);
  localparam logic [CMD_WIDTH-1:0] L_SHL1B = CMD_WIDTH'(11);
  localparam logic [CMD_WIDTH-1:0] L_ROL   = CMD_WIDTH'(12);
  localparam logic [CMD_WIDTH-1:0] L_ROR   = CMD_WIDTH'(13);

  typedef struct packed {
    logic oflow;
    logic cout;
    logic g;
    logic e;
    logic l;
    logic err;
  } flags_t;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [SHW-1:0] n);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < SHW; i++)
      if (n[i]) r = (r << (1 << i)) | (r >> (WIDTH - (1 << i)));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [SHW-1:0] n);
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < SHW; i++)
      if (n[i]) r = (r >> (1 << i)) | (r << (WIDTH - (1 << i)));
    return r;
  endfunction

  logic [WIDTH:0]         a_x, b_x, c_x, one_x, arith;
  logic [WIDTH-1:0]       lres;
  logic [SHW-1:0]         rot_amt;
  logic                   rot_bad;
  logic [1:0]             need;
  logic                   legal;
  logic [2*WIDTH-1:0]     res_d, res_q;
  flags_t                 flags_d, flags_q;

`ifdef ALU_MULT_EN
  localparam logic [2*WIDTH-1:0] ONE_W2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic                   mul_start;
  logic [2*WIDTH-1:0]     mul_x_d, mul_y_d, mul_x_q, mul_y_q;
  logic                   busy_q;
`endif

  assign a_x     = {1'b0, OPA};
  assign b_x     = {1'b0, OPB};
  assign c_x     = {{WIDTH{1'b0}}, CIN};
  assign one_x   = {{WIDTH{1'b0}}, 1'b1};
  assign rot_amt = OPB[SHW-1:0];
  assign rot_bad = |OPB[WIDTH-1:SHW];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    need    = 2'b11;
    legal   = 1'b1;
    arith   = '0;
    lres    = '0;
    res_d   = '0;
    flags_d = '0;
`ifdef ALU_MULT_EN
    mul_start = 1'b0;
    mul_x_d   = '0;
    mul_y_d   = '0;
`endif
    if (MODE) begin
      case (CMD)
        A_ADD:  begin arith = a_x + b_x;       flags_d.cout  = arith[WIDTH]; end
        A_SUB:  begin arith = a_x - b_x;       flags_d.oflow = (OPA < OPB);  end
        A_ADDC: begin arith = a_x + b_x + c_x; flags_d.cout  = arith[WIDTH]; end
        A_SUBC: begin
          arith         = a_x - b_x - c_x;
          flags_d.oflow = (a_x < (b_x + c_x));
        end
        A_INCA: begin need = 2'b01; arith = a_x + one_x; end
        A_DECA: begin need = 2'b01; arith = a_x - one_x; end
        A_INCB: begin need = 2'b10; arith = b_x + one_x; end
        A_DECB: begin need = 2'b10; arith = b_x - one_x; end
        A_CMP: begin
          flags_d.g = (OPA > OPB);
          flags_d.e = (OPA == OPB);
          flags_d.l = (OPA < OPB);
        end
`ifdef ALU_MULT_EN
        A_MULI: begin
          mul_start = 1'b1;
          mul_x_d   = {{WIDTH{1'b0}}, OPA} + ONE_W2;
          mul_y_d   = {{WIDTH{1'b0}}, OPB} + ONE_W2;
        end
        A_MULS: begin
          mul_start = 1'b1;
          mul_x_d   = {{WIDTH{1'b0}}, OPA[WIDTH-2:0], 1'b0};
          mul_y_d   = {{WIDTH{1'b0}}, OPB};
        end
`endif
        default: legal = 1'b0;
      endcase
      res_d = {{(WIDTH-1){1'b0}}, arith};
    end else begin
      case (CMD)
        L_AND:   lres = OPA & OPB;
        L_NAND:  lres = ~(OPA & OPB);
        L_OR:    lres = OPA | OPB;
        L_NOR:   lres = ~(OPA | OPB);
        L_XOR:   lres = OPA ^ OPB;
        L_XNOR:  lres = ~(OPA ^ OPB);
        L_NOTA:  begin need = 2'b01; lres = ~OPA;     end
        L_NOTB:  begin need = 2'b10; lres = ~OPB;     end
        L_SHR1A: begin need = 2'b01; lres = OPA >> 1; end
        L_SHL1A: begin need = 2'b01; lres = OPA << 1; end
        L_SHR1B: begin need = 2'b10; lres = OPB >> 1; end
        L_SHL1B: begin need = 2'b10; lres = OPB << 1; end
        // Out-of-range rotate amount still rotates by the low bits but flags ERR
        L_ROL:   begin lres = rotl(OPA, rot_amt); flags_d.err = rot_bad; end
        L_ROR:   begin lres = rotr(OPA, rot_amt); flags_d.err = rot_bad; end
        default: legal = 1'b0;
      endcase
      res_d = {{WIDTH{1'b0}}, lres};
    end

    if (!legal || ((INP_VALID & need) != need)) begin
      res_d       = '0;
      flags_d     = '0;
      flags_d.err = 1'b1;
`ifdef ALU_MULT_EN
      mul_start   = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
    if (!RST) begin
      res_q   <= '0;
      flags_q <= '0;
`ifdef ALU_MULT_EN
      busy_q  <= 1'b0;
      mul_x_q <= '0;
      mul_y_q <= '0;
`endif
    end else if (CE) begin
`ifdef ALU_MULT_EN
      // While busy, the captured product is presented and the inputs are ignored
      if (busy_q) begin
        res_q   <= mul_x_q * mul_y_q;
        flags_q <= '0;
        busy_q  <= 1'b0;
      end else if (mul_start) begin
        busy_q  <= 1'b1;
        mul_x_q <= mul_x_d;
        mul_y_q <= mul_y_d;
      end else begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
`else
      res_q   <= res_d;
      flags_q <= flags_d;
`endif
    end
  end

  assign RES   = res_q;
  assign OFLOW = flags_q.oflow;
  assign COUT  = flags_q.cout;
  assign G     = flags_q.g;
  assign E     = flags_q.e;
  assign L     = flags_q.l;
  assign ERR   = flags_q.err;

endmodule

// File: tb/tb_alu_design.sv
// Self-checking bench for alu_design: integer reference model compared every cycle, plus literal spot checks.
// Build with ALU_MULT_EN defined to exercise the two-cycle multiply path.
module tb_alu_design;

  localparam int W = 8;

  logic        CLK, RST, CE, MODE, CIN;
  logic [1:0]  INP_VALID;
  logic [3:0]  CMD;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        OFLOW, COUT, G, E, L, ERR;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  typedef struct packed {
    logic [15:0] res;
    logic oflow, cout, g, e, l, err;
  } out_t;

  out_t dut_o, exp_o;
  bit   pend;
  int   pend_res;

  assign dut_o = {RES, OFLOW, COUT, G, E, L, ERR};

  alu_design #(.WIDTH(W), .CMD_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .OFLOW(OFLOW), .COUT(COUT),
    .G(G), .E(E), .L(L), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the command tables
  function automatic out_t eval(input bit mode, input int cmd, input bit [1:0] iv,
                                input int a, input int b, input bit cin);
    out_t o;
    int   need, r, n;
    bit   legal;
    o = '0; need = 3; legal = 1; r = 0; n = b % W;
    if (mode) begin
      case (cmd)
        0: begin r = a + b;       o.cout  = (r >= 256);    end
        1: begin r = a - b;       o.oflow = (a < b);       end
        2: begin r = a + b + cin; o.cout  = (r >= 256);    end
        3: begin r = a - b - cin; o.oflow = (a < b + cin); end
        4: begin need = 1; r = a + 1; end
        5: begin need = 1; r = a - 1; end
        6: begin need = 2; r = b + 1; end
        7: begin need = 2; r = b - 1; end
        8: begin o.g = (a > b); o.e = (a == b); o.l = (a < b); end
`ifdef ALU_MULT_EN
        9, 10: need = 3;
`endif
        default: legal = 0;
      endcase
      o.res = 16'(r & 511);
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = ~(a & b);
        2:  r = a | b;
        3:  r = ~(a | b);
        4:  r = a ^ b;
        5:  r = ~(a ^ b);
        6:  begin need = 1; r = ~a;     end
        7:  begin need = 2; r = ~b;     end
        8:  begin need = 1; r = a >> 1; end
        9:  begin need = 1; r = a << 1; end
        10: begin need = 2; r = b >> 1; end
        11: begin need = 2; r = b << 1; end
        12: begin r = (a << n) | (a >> (W - n)); o.err = (b >= W); end
        13: begin r = (a >> n) | (a << (W - n)); o.err = (b >= W); end
        default: legal = 0;
      endcase
      o.res = 16'(r & 255);
    end
    if (!legal || ((iv & need) != need)) begin
      o = '0;
      o.err = 1'b1;
    end
    return o;
  endfunction

  function automatic bit is_mul_start(input bit mode, input int cmd, input bit [1:0] iv);
`ifdef ALU_MULT_EN
    return mode && (cmd == 9 || cmd == 10) && (iv == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mul_product(input int cmd, input int a, input int b);
    if (cmd == 9) return ((a + 1) * (b + 1)) & 65535;
    return (((a << 1) & 255) * b) & 65535;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_o    <= '0;
      pend     <= 1'b0;
      pend_res <= 0;
    end else if (CE) begin
      if (pend) begin
        exp_o <= {16'(pend_res), 6'b0};
        pend  <= 1'b0;
      end else if (is_mul_start(MODE, int'(CMD), INP_VALID)) begin
        pend     <= 1'b1;
        pend_res <= mul_product(int'(CMD), int'(OPA), int'(OPB));
      end else begin
        exp_o <= eval(MODE, int'(CMD), INP_VALID, int'(OPA), int'(OPB), CIN);
      end
    end
  end

  always @(negedge CLK)
    if (cmp_en) check("model", 32'(dut_o), 32'(exp_o));

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    MODE      = 1'($urandom);
    CMD       = 4'($urandom);
    INP_VALID = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
    OPA       = pick_operand();
    OPB       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : pick_operand();
    CIN       = 1'($urandom);
  endtask

  // Drive one command at a falling edge; returns after the next rising edge has registered it
  task automatic apply(input bit m, input logic [3:0] c, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b, input bit ci);
    CE = 1'b1; MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
    @(negedge CLK);
  endtask

  task automatic expect_out(input string name, input logic [15:0] r, input logic [5:0] f);
    check(name, 32'(dut_o), 32'({r, f}));
  endtask

  initial begin
    RST = 1'b0;
    CE  = 1'b1;
    rand_inputs();
    repeat (2) begin
      rand_inputs();
      @(negedge CLK);
    end
    expect_out("reset", 16'h0000, 6'b000000);
    cmp_en = 1'b1;
    RST    = 1'b1;

    // Flags order: {oflow, cout, g, e, l, err}
    apply(1, 4'd0,  2'b11, 8'hFF, 8'h01, 0); expect_out("add_carry",    16'h0100, 6'b010000);
    apply(1, 4'd3,  2'b11, 8'h05, 8'h05, 1); expect_out("sub_cin_wrap", 16'h01FF, 6'b100000);
    apply(1, 4'd8,  2'b11, 8'h10, 8'h20, 0); expect_out("cmp_less",     16'h0000, 6'b000010);
    apply(0, 4'd12, 2'b11, 8'h81, 8'h01, 0); expect_out("rol_ok",       16'h0003, 6'b000000);
    apply(0, 4'd12, 2'b11, 8'h81, 8'h11, 0); expect_out("rol_bad_amt",  16'h0003, 6'b000001);
    apply(0, 4'd1,  2'b11, 8'hF0, 8'hFF, 0); expect_out("nand",         16'h000F, 6'b000000);
    apply(0, 4'd0,  2'b01, 8'hFF, 8'hFF, 0); expect_out("missing_opb",  16'h0000, 6'b000001);
    apply(1, 4'd4,  2'b01, 8'h7F, 8'h00, 0); expect_out("inc_a",        16'h0080, 6'b000000);
    apply(1, 4'd14, 2'b11, 8'h12, 8'h34, 0); expect_out("illegal_cmd",  16'h0000, 6'b000001);
    apply(1, 4'd0,  2'b11, 8'h10, 8'h20, 0); expect_out("add_pre_ce",   16'h0030, 6'b000000);
    repeat (3) begin
      rand_inputs();
      CE = 1'b0;
      @(negedge CLK);
      expect_out("ce_freeze", 16'h0030, 6'b000000);
    end

`ifdef ALU_MULT_EN
    apply(1, 4'd9,  2'b11, 8'h02, 8'h03, 0); expect_out("mul_capture_hold", 16'h0030, 6'b000000);
    apply(1, 4'd0,  2'b11, 8'hFF, 8'hFF, 0); expect_out("mul_inc",          16'h000C, 6'b000000);
    apply(1, 4'd10, 2'b11, 8'h81, 8'h02, 0); expect_out("mul_shl_hold",     16'h000C, 6'b000000);
    apply(1, 4'd1,  2'b11, 8'h00, 8'h01, 0); expect_out("mul_shl",          16'h0004, 6'b000000);
    apply(1, 4'd9,  2'b11, 8'h04, 8'h04, 0); expect_out("mul_ce_hold",      16'h0004, 6'b000000);
    repeat (3) begin
      rand_inputs();
      CE = 1'b0;
      @(negedge CLK);
      expect_out("mul_ce_freeze", 16'h0004, 6'b000000);
    end
    apply(1, 4'd0,  2'b11, 8'h01, 8'h01, 0); expect_out("mul_after_ce",     16'h0019, 6'b000000);
    apply(1, 4'd9,  2'b11, 8'h07, 8'h07, 0); expect_out("mul_rst_hold",     16'h0019, 6'b000000);
`else
    apply(1, 4'd9,  2'b11, 8'h02, 8'h03, 0); expect_out("mul9_illegal",     16'h0000, 6'b000001);
    apply(1, 4'd10, 2'b11, 8'h81, 8'h02, 0); expect_out("mul10_illegal",    16'h0000, 6'b000001);
`endif
    RST = 1'b0;
    @(negedge CLK);
    expect_out("mid_reset", 16'h0000, 6'b000000);
    RST = 1'b1;
    apply(0, 4'd0, 2'b11, 8'hFF, 8'h0F, 0); expect_out("no_late_result", 16'h000F, 6'b000000);

    repeat (3000) begin
      rand_inputs();
      CE  = ($urandom_range(0, 9) != 0);
      RST = ($urandom_range(0, 99) != 0);
      @(negedge CLK);
    end
    RST = 1'b1;
    CE  = 1'b1;
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
